systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Upstream stage of the 4x4 systolic PE array.
- Accepts operand words from the DMA stream and buffers one A tile (N x K) and one B tile (K x N).
- Replays both tiles into the array's row and column edges with diagonal skew, one step per clock.
- Then holds valid low for N cycles so the PEs shift their accumulators out through the column outputs, and pulses done.

Parameters:
DATA_W, 32, operand word width
N, 4, array dimension (number of row lanes and column lanes)
K, 4, inner (reduction) dimension

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous, active-low reset
s_tdata  input  DATA_W  operand word from DMA
s_tvalid  input  1  s_tdata valid
s_tready  output  1  feeder can accept a word
s_tlast  input  1  last word of tile pair
row_out  output  N*DATA_W  lane i at bits [i*DATA_W +: DATA_W], drives PE row i left edge
col_out  output  N*DATA_W  lane j, drives PE column j top edge
row_valid  output  N  per-row-lane valid
col_valid  output  N  per-column-lane valid
busy  output  1  state is not IDLE
done  output  1  one-cycle pulse when the drain completes
err  output  1  sticky framing error; tied 0 unless FEEDER_TLAST_CHK_EN

Behaviour:
- Clock and reset are fixed: one clock, i_clk; reset i_rst is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; all counters 0. Operand storage is not reset.
- Reset mid-operation aborts immediately. Outputs go to 0 in the same instant. After release the block is in IDLE and must be reloaded.
- Handshake:
  - A word transfers on any i_clk edge where s_tvalid and s_tready are both high.
  - s_tready = 1 in IDLE and LOAD, 0 otherwise.
  - Gaps in s_tvalid stall the load counter; they are not errors.
- Word order: words 0..N*K-1 are A, row-major (A[i][k] = word i*K+k). Words N*K..2*N*K-1 are B, row-major (B[k][j] = word N*K+k*N+j).
- States:
  - IDLE: the first accepted word is stored at index 0; go to LOAD.
  - LOAD: store words at incrementing indices. When index 2*N*K-1 is accepted, go to FEED with feed_cnt=0.
  - FEED: lasts exactly K+N-1 cycles; feed_cnt=t counts 0..K+N-2. Then go to DRAIN.
  - DRAIN: lasts N cycles. All valids are 0 and all col_out lanes are 0 (PEs shift their accumulators down). Then go to DONE.
  - DONE: done=1 for one cycle, then IDLE. s_tready is 0 in DONE; it returns to 1 in the following IDLE cycle.
- Skew rule, during FEED step t:
  - Row lane i: row_valid[i] = (0 <= t-i < K). When valid, row_out lane i = A[i][t-i]; otherwise 0.
  - Column lane j: col_valid[j] = (0 <= t-j < K). When valid, col_out lane j = B[t-j][j]; otherwise 0.
- Timing: outputs are a decode of registered state (state, feed_cnt, storage). Step t is visible during the t-th FEED cycle, with no added latency.
- Arithmetic: no data arithmetic; words pass through bit-exact. Counter widths are $clog2(2*N*K), $clog2(K+N-1) and $clog2(N+1).
- Outside FEED, row_out, col_out, row_valid and col_valid are all 0.

Optional Feature:
- Macro: FEEDER_TLAST_CHK_EN.
- With the macro defined:
  - s_tlast on any accepted word other than index 2*N*K-1, or missing on that word, sets err.
  - On the error the block returns to IDLE without entering FEED.
  - err clears only on reset.
- Without the macro: s_tlast is ignored and err is constant 0.

Decomposition:
- Shared package systolic_pkg holds:
  - default constants N, K, DATA_W;
  - the state enum IDLE/LOAD/FEED/DRAIN/DONE;
  - index helper constants A_WORDS = N*K and TOTAL_WORDS = 2*N*K.
- One natural sub-module, skew_lane_sel: given lane index, feed_cnt and the tile storage, it returns that lane's element and valid. It is instantiated N times for rows and N times for columns.

Test Plan:
- Load words 1..32 back-to-back with s_tlast on word 32. Expect the FEED checks below, then DRAIN for 4 cycles, then done high for exactly one cycle.
  - FEED t=0: row lane 0 = 1, col lane 0 = 17, row_valid = 4'b0001, col_valid = 4'b0001.
  - FEED t=3: row_valid = 4'b1111; row lanes 0..3 = 4, 7, 10, 13; col lanes 0..3 = 29, 26, 23, 20.
  - FEED t=6: row_valid = col_valid = 4'b1000; row lane 3 = 16, col lane 3 = 32.
- Same 32 words with s_tvalid low every other cycle. Expect identical FEED output sequence; s_tready is 0 from FEED entry until done.
- Reset asserted at FEED t=2. Expect all outputs 0 immediately and busy=0. A fresh load then gives the same t=0 values as the first scenario.
- With FEEDER_TLAST_CHK_EN defined, s_tlast on word 20: err=1, no FEED cycles occur, and the block accepts a new load afterwards. Without the macro, the same stimulus runs normally and err stays 0.
- Drain check: DRAIN cycles show col_out=0, all valids 0, and busy=1 for 4 cycles.
- Back-to-back tiles: the second tile starts loading in the first IDLE cycle after done, with no lost word.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants and FSM state encoding for the systolic array front end.
package systolic_pkg;

    localparam int N           = 4;
    localparam int K           = 4;
    localparam int DATA_W      = 32;
    localparam int A_WORDS     = N * K;
    localparam int TOTAL_WORDS = 2 * N * K;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/systolic_skew_feeder_skew_lane_sel.sv
// Purpose: picks one edge lane's operand for the current skewed feed step.
// Latency: combinational.
// Backpressure: none; pure decode of feed_cnt and the stored tile.
module skew_lane_sel
    import systolic_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int K      = 4,
    parameter int FW     = 3,
    parameter int LANE   = 0,
    parameter bit IS_COL = 1'b0
) (
    input  logic [FW-1:0]         feed_cnt,
    input  logic [N*K*DATA_W-1:0] tile,
    output logic [DATA_W-1:0]     dat,
    output logic                  vld
);

    localparam int ELEMS = N * K;
    localparam int IW    = $clog2(ELEMS);

    logic [DATA_W-1:0] words [ELEMS];
    logic [IW-1:0]     idx;
    int                k;
    int                e;

    for (genvar g = 0; g < ELEMS; g++) begin : g_word
        assign words[g] = tile[g*DATA_W +: DATA_W];
    end

    // Row lanes walk A[LANE][k]; column lanes walk B[k][LANE], both row-major.
    always_comb begin
        k   = int'(feed_cnt) - LANE;
        vld = (k >= 0) && (k < K);
        e   = IS_COL ? (k * N + LANE) : (LANE * K + k);
        if (!vld) begin
            e = 0;
        end
        idx = IW'(e);
        dat = vld ? words[idx] : '0;
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Purpose: buffers an A/B tile pair from DMA and replays it diagonally skewed into a systolic array; optional FEEDER_TLAST_CHK_EN enables tlast framing checks.
// Latency: feed step t is visible in the t-th FEED cycle, directly after the last word is accepted.
// Backpressure: s_tready high only in IDLE/LOAD; stalls while feeding, draining and signalling done.
module systolic_skew_feeder #(
    parameter int DATA_W = 32,
    parameter int N      = 4,
    parameter int K      = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    output logic [N*DATA_W-1:0] row_out,
    output logic [N*DATA_W-1:0] col_out,
    output logic [N-1:0]        row_valid,
    output logic [N-1:0]        col_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    import systolic_pkg::*;

    localparam int A_CNT     = N * K;
    localparam int TOT_CNT   = 2 * N * K;
    localparam int IDX_W     = $clog2(TOT_CNT);
    localparam int FEED_W    = $clog2(K + N - 1);
    localparam int DRN_W     = $clog2(N + 1);
    localparam int FEED_LAST = K + N - 2;

    state_t              state_q;
    logic [IDX_W-1:0]    load_idx_q;
    logic [FEED_W-1:0]   feed_cnt_q;
    logic [DRN_W-1:0]    drain_cnt_q;
    logic                err_q;

    logic [DATA_W-1:0]         mem [TOT_CNT];
    logic [TOT_CNT*DATA_W-1:0] tile;

    logic accept;
    logic last_word;
    logic frame_err;
    logic in_feed;

    assign s_tready  = (state_q == IDLE) || (state_q == LOAD);
    assign accept    = s_tvalid && s_tready;
    assign last_word = (load_idx_q == IDX_W'(TOT_CNT - 1));
    assign in_feed   = (state_q == FEED);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;

`ifdef FEEDER_TLAST_CHK_EN
    assign frame_err = accept && (s_tlast != last_word);
`else
    logic unused_tlast;
    assign unused_tlast = s_tlast;
    assign frame_err    = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            load_idx_q  <= '0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (frame_err) begin
                            // Misframed tile is dropped; the next word restarts at index 0.
                            state_q    <= IDLE;
                            load_idx_q <= '0;
                            err_q      <= 1'b1;
                        end else if (last_word) begin
                            state_q    <= FEED;
                            load_idx_q <= '0;
                            feed_cnt_q <= '0;
                        end else begin
                            state_q    <= LOAD;
                            load_idx_q <= load_idx_q + 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (feed_cnt_q == FEED_W'(FEED_LAST)) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end else begin
                        feed_cnt_q <= feed_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == DRN_W'(N - 1)) begin
                        state_q <= DONE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[load_idx_q] <= s_tdata;
        end
    end

    for (genvar g = 0; g < TOT_CNT; g++) begin : g_pack
        assign tile[g*DATA_W +: DATA_W] = mem[g];
    end

    logic [DATA_W-1:0] row_dat [N];
    logic [DATA_W-1:0] col_dat [N];
    logic [N-1:0]      row_vld;
    logic [N-1:0]      col_vld;

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_lane_sel #(
            .DATA_W (DATA_W),
            .N      (N),
            .K      (K),
            .FW     (FEED_W),
            .LANE   (g),
            .IS_COL (1'b0)
        ) u_row (
            .feed_cnt (feed_cnt_q),
            .tile     (tile[A_CNT*DATA_W-1:0]),
            .dat      (row_dat[g]),
            .vld      (row_vld[g])
        );

        skew_lane_sel #(
            .DATA_W (DATA_W),
            .N      (N),
            .K      (K),
            .FW     (FEED_W),
            .LANE   (g),
            .IS_COL (1'b1)
        ) u_col (
            .feed_cnt (feed_cnt_q),
            .tile     (tile[TOT_CNT*DATA_W-1:A_CNT*DATA_W]),
            .dat      (col_dat[g]),
            .vld      (col_vld[g])
        );

        assign row_out[g*DATA_W +: DATA_W] = in_feed ? row_dat[g] : '0;
        assign col_out[g*DATA_W +: DATA_W] = in_feed ? col_dat[g] : '0;
    end

    assign row_valid = in_feed ? row_vld : '0;
    assign col_valid = in_feed ? col_vld : '0;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: tile loads, skewed replay, drain/done timing, reset abort, tlast handling.
module tb_systolic_skew_feeder;

    localparam int DW         = 32;
    localparam int NN         = 4;
    localparam int KK         = 4;
    localparam int TOT        = 2 * NN * KK;
    localparam int FEED_STEPS = KK + NN - 1;

    logic              i_clk;
    logic              i_rst;
    logic [DW-1:0]     s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [NN*DW-1:0]  row_out;
    logic [NN*DW-1:0]  col_out;
    logic [NN-1:0]     row_valid;
    logic [NN-1:0]     col_valid;
    logic              busy;
    logic              done;
    logic              err;

    systolic_skew_feeder #(.DATA_W(DW), .N(NN), .K(KK)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .row_out   (row_out),
        .col_out   (col_out),
        .row_valid (row_valid),
        .col_valid (col_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [NN*DW-1:0] row;
        logic [NN*DW-1:0] col;
        logic [NN-1:0]    rv;
        logic [NN-1:0]    cv;
    } step_t;

    typedef struct {
        int               t;
        logic [NN-1:0]    rv;
        logic [NN-1:0]    cv;
        logic [NN*DW-1:0] row;
        logic [NN*DW-1:0] col;
    } vec_t;

    step_t       sb[$];
    step_t       cap[FEED_STEPS];
    vec_t        vec[3];
    logic [DW-1:0] mdl[TOT];
    int          tests;
    int          fails;
    logic        err_exp;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [NN*DW-1:0] act, input logic [NN*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic step_t exp_step(input int t);
        step_t s;
        s = '0;
        for (int i = 0; i < NN; i++) begin
            int k;
            k = t - i;
            if (k >= 0 && k < KK) begin
                s.rv[i]            = 1'b1;
                s.row[i*DW +: DW]  = mdl[i*KK + k];
                s.cv[i]            = 1'b1;
                s.col[i*DW +: DW]  = mdl[NN*KK + k*NN + i];
            end
        end
        return s;
    endfunction

    task automatic load_tile(input int base, input bit gaps, input int tlast_idx);
        for (int w = 0; w < TOT; w++) begin
            if (gaps) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                @(posedge i_clk); #1;
                chk("gap_tready", s_tready, 1);
            end
            s_tvalid = 1'b1;
            s_tdata  = DW'(base + w);
            s_tlast  = (w == tlast_idx);
            mdl[w]   = DW'(base + w);
            @(posedge i_clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int t = 0; t < FEED_STEPS; t++) sb.push_back(exp_step(t));
    endtask

    // Starts at the first FEED cycle; returns in the first IDLE cycle after done.
    task automatic observe(input string tag);
        for (int c = 0; c < FEED_STEPS + NN + 2; c++) begin
            if (c < FEED_STEPS) begin
                step_t e;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s_sb_empty: got no expected entry at step %0d", tag, c);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("%s_row_t%0d", tag, c), row_out, e.row);
                    chk($sformatf("%s_col_t%0d", tag, c), col_out, e.col);
                    chk($sformatf("%s_rv_t%0d", tag, c), row_valid, e.rv);
                    chk($sformatf("%s_cv_t%0d", tag, c), col_valid, e.cv);
                end
                cap[c] = {row_out, col_out, row_valid, col_valid};
                chk($sformatf("%s_feed_rdy", tag), s_tready, 0);
                chk($sformatf("%s_feed_busy", tag), busy, 1);
                chk($sformatf("%s_feed_done", tag), done, 0);
            end else if (c < FEED_STEPS + NN) begin
                chk($sformatf("%s_drain_col", tag), col_out, 0);
                chk($sformatf("%s_drain_row", tag), row_out, 0);
                chk($sformatf("%s_drain_vld", tag), {row_valid, col_valid}, 0);
                chk($sformatf("%s_drain_busy", tag), busy, 1);
                chk($sformatf("%s_drain_done", tag), done, 0);
                chk($sformatf("%s_drain_rdy", tag), s_tready, 0);
            end else if (c == FEED_STEPS + NN) begin
                chk($sformatf("%s_done_pulse", tag), done, 1);
                chk($sformatf("%s_done_rdy", tag), s_tready, 0);
            end else begin
                chk($sformatf("%s_idle_done", tag), done, 0);
                chk($sformatf("%s_idle_busy", tag), busy, 0);
                chk($sformatf("%s_idle_rdy", tag), s_tready, 1);
            end
            chk($sformatf("%s_err", tag), err, err_exp);
            if (c != FEED_STEPS + NN + 1) begin
                @(posedge i_clk); #1;
            end
        end
    endtask

    task automatic table_check(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_vec%0d_rv", tag, i), cap[vec[i].t].rv, vec[i].rv);
            chk($sformatf("%s_vec%0d_cv", tag, i), cap[vec[i].t].cv, vec[i].cv);
            chk($sformatf("%s_vec%0d_row", tag, i), cap[vec[i].t].row, vec[i].row);
            chk($sformatf("%s_vec%0d_col", tag, i), cap[vec[i].t].col, vec[i].col);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        err_exp  = 1'b0;
        vec[0] = '{0, 4'b0001, 4'b0001, {96'd0, 32'd1}, {96'd0, 32'd17}};
        vec[1] = '{3, 4'b1111, 4'b1111, {32'd13, 32'd10, 32'd7, 32'd4}, {32'd20, 32'd23, 32'd26, 32'd29}};
        vec[2] = '{6, 4'b1000, 4'b1000, {32'd16, 96'd0}, {32'd32, 96'd0}};

        i_rst    = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_row", row_out, 0);
        chk("rst_col", col_out, 0);
        chk("rst_vld", {row_valid, col_valid}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        chk("idle_rdy", s_tready, 1);

        // Back-to-back load of words 1..32, then a second tile with no idle gap.
        load_tile(1, 1'b0, TOT - 1);
        observe("s1");
        table_check("s1");
        load_tile(201, 1'b0, TOT - 1);
        observe("b2b");

        load_tile(1, 1'b1, TOT - 1);
        observe("gap");
        table_check("gap");

        // Reset abort in the middle of FEED.
        load_tile(1, 1'b0, TOT - 1);
        chk("abort_t0_rv", row_valid, 4'b0001);
        repeat (2) begin
            @(posedge i_clk); #1;
        end
        chk("abort_t2_rv", row_valid, 4'b0111);
        i_rst = 1'b0;
        #1;
        chk("abort_row", row_out, 0);
        chk("abort_col", col_out, 0);
        chk("abort_vld", {row_valid, col_valid}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        sb.delete();
        #2;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        load_tile(1, 1'b0, TOT - 1);
        observe("rld");
        table_check("rld");

`ifdef FEEDER_TLAST_CHK_EN
        for (int w = 0; w < 20; w++) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(500 + w);
            s_tlast  = (w == 19);
            @(posedge i_clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        err_exp  = 1'b1;
        chk("tlast_err", err, 1);
        chk("tlast_busy", busy, 0);
        repeat (3) begin
            @(posedge i_clk); #1;
            chk("tlast_nofeed_vld", {row_valid, col_valid}, 0);
            chk("tlast_nofeed_busy", busy, 0);
        end
        load_tile(1, 1'b0, TOT - 1);
        observe("post_err");
        table_check("post_err");
`else
        load_tile(1, 1'b0, 19);
        observe("tlast_ign");
        table_check("tlast_ign");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
